fetch_unit: RTL

Instruction fetch stage that feeds the control unit and datapath. It owns the program counter and issues sequential word requests to instruction memory. Returned instructions are buffered and presented to decode with a valid/ready handshake. A taken branch or jump from the control unit (PCSrc plus target) redirects fetch: the buffer is flushed and stale in-flight responses are discarded.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 59 +++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, decode and redirect signals of the fetch stage
interface fetch_if import fetch_pkg::*; #(
    parameter int W = XLEN
) ();
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         instr_valid;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_ready;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer; flush beats push, a pop during flush is harmless
module fetch_fifo import fetch_pkg::*; #(
    parameter int XLEN = fetch_pkg::XLEN,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o,
    output logic [CW-1:0]   count_o,
    output logic            empty_o
);
    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   cnt_q;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= inc(wr_q);
            end
            if (pop_i) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, in-flight tracking and credit-based request issue
module fetch_unit import fetch_pkg::*; #(
    parameter int XLEN = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::RESET_PC),
    parameter int DEPTH = 2
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [XLEN-1:0] pc_q, pc_d, head_pc_q, head_pc_d, target, head_word;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d, count;
    logic [CW:0]     occ;
    logic            pop, rsp, push, req, fire, empty;
    // out_q counts every granted word still in flight, including those marked for dropping
    assign target = bus.redirect_pc & ~XLEN'(3);
    assign pop    = ~empty & bus.instr_ready;
    assign rsp    = bus.imem_rvalid & (out_q != '0);
    assign occ    = {1'b0, out_q} + {1'b0, count} - (CW+1)'(pop);
    assign req    = ~rst & ~bus.redirect & (occ < (CW+1)'(DEPTH));
    assign fire   = req & bus.imem_gnt;
    assign push   = rsp & (drop_q == '0) & ~bus.redirect;
    always_comb begin
        pc_d      = bus.redirect ? target : fire ? pc_q + XLEN'(INSTR_BYTES) : pc_q;
        head_pc_d = bus.redirect ? target : pop ? head_pc_q + XLEN'(INSTR_BYTES) : head_pc_q;
        out_d     = out_q + CW'(fire) - CW'(rsp);
        drop_d    = bus.redirect ? out_q - CW'(rsp) : drop_q - CW'(rsp & (drop_q != '0));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            head_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            head_pc_q <= head_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
        end
    end
    fetch_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect),
        .data_i  (bus.imem_rdata),
        .data_o  (head_word),
        .count_o (count),
        .empty_o (empty)
    );
    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = ~empty;
    assign bus.instr       = head_word;
    assign bus.instr_pc    = head_pc_q;
endmodule
